// File: rtl/foutbit_sched.sv
// Round-robin scheduler sharing one external 4-bit adder slice between two
// requesters; each grant runs a NIB-nibble add LSB-first with a registered carry.
module foutbit_sched #(
  parameter int NIB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [4*NIB-1:0]  a0,
  input  logic [4*NIB-1:0]  b0,
  input  logic [4*NIB-1:0]  a1,
  input  logic [4*NIB-1:0]  b1,
  input  logic              cin0,
  input  logic              cin1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [4*NIB-1:0]  sum,
  output logic              cout,
  output logic              owner,
  output logic              busy,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_cin,
  input  logic [3:0]        add_s,
  input  logic              add_cout
);
  localparam int W  = 4 * NIB;
  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [KW-1:0]   r_k;
  logic [KW+1:0]   w_base;
  logic            r_carry, r_cin, r_idx, r_ptr;
  logic            r_gnt0, r_gnt1;
  logic [W-1:0]    r_a, r_b, r_work, w_final;
  logic [W-1:0]    r_sum;
  logic            r_cout, r_owner;
  logic            w_any, w_win, w_grant, w_last_nib;

  // Arbitration and next state; r_ptr holds the last-served requester
  always_comb begin
    w_any      = req0 | req1;
    w_win      = (req0 && req1) ? ~r_ptr : req1;
    w_grant    = (r_state != S_RUN) && w_any;
    w_last_nib = (r_state == S_RUN) && (r_k == KW'(NIB - 1));
    w_next     = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_RUN;
      S_RUN:   if (w_last_nib) w_next = S_DONE;
      S_DONE:  w_next = w_any ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Slice operand steering; zero outside RUN
  always_comb begin
    w_base  = {r_k, 2'b00};
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_a[w_base +: 4];
      add_b   = r_b[w_base +: 4];
      add_cin = (r_k == '0) ? r_cin : r_carry;
    end
    w_final = r_work;
    w_final[4*(NIB-1) +: 4] = add_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_idx   <= 1'b0;
      r_ptr   <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt0  <= w_grant && !w_win;
      r_gnt1  <= w_grant && w_win;
      if (w_grant) begin
        r_idx <= w_win;
        r_ptr <= w_win;
        r_k   <= '0;
      end else if (r_state == S_RUN) begin
        r_k     <= r_k + 1'b1;
        r_carry <= add_cout;
        if (w_last_nib) begin
          r_sum   <= w_final;
          r_cout  <= add_cout;
          r_owner <= r_idx;
        end
      end
    end
  end

  // Operand and work registers carry no control meaning, so they skip reset
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_a   <= w_win ? a1 : a0;
      r_b   <= w_win ? b1 : b0;
      r_cin <= w_win ? cin1 : cin0;
    end else if (r_state == S_RUN) begin
      r_work[w_base +: 4] <= add_s;
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = (r_state == S_DONE) && !r_owner;
  assign done1 = (r_state == S_DONE) && r_owner;
  assign busy  = (r_state == S_RUN);
  assign sum   = r_sum;
  assign cout  = r_cout;
  assign owner = r_owner;

endmodule

// File: tb/tb_foutbit_sched.sv
// Scoreboard bench for foutbit_sched: driver predicts arbitration and sums,
// monitor pops expectations whenever a done pulse appears.
module tb_foutbit_sched;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          cin0 = 1'b0, cin1 = 1'b0;
  logic          gnt0, gnt1, done0, done1, cout, owner, busy, add_cin, add_cout;
  logic [W-1:0]  sum;
  logic [3:0]    add_a, add_b, add_s;

  foutbit_sched #(.NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .sum(sum), .cout(cout), .owner(owner), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // External ripple slice
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  always #5 clk = ~clk;

  typedef struct {
    bit           own;
    logic [W-1:0] s;
    bit           c;
  } exp_t;

  exp_t q[$];
  int   gq[$];
  int   dq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   gcount = 0;
  bit   m_last = 1'b1;
  logic [W-1:0] h_sum = '0;
  bit   h_cout = 1'b0, h_own = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W:0] act, logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      gq.delete();
      h_sum  = '0;
      h_cout = 1'b0;
      h_own  = 1'b0;
    end else begin
      chk("gnt_onehot", (W+1)'(gnt0 & gnt1), '0);
      chk("done_onehot", (W+1)'(done0 & done1), '0);
      if (gnt0 | gnt1) begin
        gq.push_back(cyc);
        gcount++;
      end
      if (done0 | done1) begin
        dq.push_back(cyc);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_who", (W+1)'(done1), (W+1)'(e.own));
          chk("owner", (W+1)'(owner), (W+1)'(e.own));
          chk("sum", (W+1)'(sum), (W+1)'(e.s));
          chk("cout", (W+1)'(cout), (W+1)'(e.c));
          if (gq.size() == 0) chk("latency_nogrant", 1, 0);
          else chk("latency", (W+1)'(cyc - gq.pop_front()), (W+1)'(NIB));
          h_sum  = e.s;
          h_cout = e.c;
          h_own  = e.own;
        end
      end else begin
        chk("hold", {cout, sum}, {h_cout, h_sum});
        chk("hold_owner", (W+1)'(owner), (W+1)'(h_own));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit arb(bit p0, bit p1);
    if (p0 && p1) return !m_last;
    return p1;
  endfunction

  task automatic predict(bit w, logic [W-1:0] a, logic [W-1:0] b, bit c);
    logic [W:0] full;
    exp_t e;
    full  = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    e.own = w;
    e.s   = full[W-1:0];
    e.c   = full[W];
    m_last = w;
    q.push_back(e);
  endtask

  task automatic wait_gnt(bit w);
    for (int i = 0; i < 3 * NIB + 6; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) break;
    end
    chk("gnt_seen", (W+1)'(gnt0 | gnt1), 1);
    chk("gnt_who", (W+1)'({gnt1, gnt0}), w ? 2 : 1);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain", (W+1)'(q.size()), 0);
    tick();
  endtask

  task automatic check_reset_vals();
    chk("rst_ctrl", (W+1)'({gnt0, gnt1, done0, done1, busy, owner}), 0);
    chk("rst_sum", {cout, sum}, 0);
    chk("rst_slice", (W+1)'({add_a, add_b, add_cin}), 0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    m_last = 1'b1;
    tick();
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_single(bit r, logic [W-1:0] a, logic [W-1:0] b, bit c, bit ripple);
    if (r) begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
    else   begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
    predict(arb(!r, r), a, b, c);
    wait_gnt(r);
    if (r) req1 = 1'b0; else req0 = 1'b0;
    if (ripple) begin
      for (int k = 1; k < NIB; k++) begin
        @(negedge clk);
        chk("add_cin_ripple", (W+1)'(add_cin), 1);
      end
      #1;
    end
    wait_drain();
  endtask

  initial begin
    int base;
    int g_before;
    bit p0, p1, w;

    do_reset();

    do_single(1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    do_single(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    do_single(1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0);

    // Both requesters held continuously: alternation and spacing
    do_reset();
    a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b1;
    a1 = 16'hF0F0; b1 = 16'h0F10; cin1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    base = dq.size();
    for (int i = 0; i < 4; i++) begin
      w = arb(1'b1, 1'b1);
      chk("tie_order", (W+1)'(w), (W+1)'(i % 2));
      if (w) predict(w, a1, b1, cin1);
      else   predict(w, a0, b0, cin0);
      wait_gnt(w);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    wait_drain();
    if (dq.size() >= base + 4) begin
      for (int i = 1; i < 4; i++)
        chk("done_spacing", (W+1)'(dq[base+i] - dq[base+i-1]), (W+1)'(NIB + 1));
    end else begin
      chk("done_count", (W+1)'(dq.size() - base), 4);
    end

    // Reset in the middle of RUN aborts the operation
    a0 = 16'hABCD; b0 = 16'h1357; cin0 = 1'b0; req0 = 1'b1;
    predict(arb(1'b1, 1'b0), a0, b0, cin0);
    wait_gnt(1'b0);
    req0 = 1'b0;
    tick();
    tick();
    do_reset();
    for (int i = 0; i < NIB + 2; i++) tick();
    check_reset_vals();
    do_single(1'b1, 16'h4321, 16'h8765, 1'b1, 1'b0);

    // Withdrawn request while busy
    a1 = 16'h0F0F; b1 = 16'hF0F1; cin1 = 1'b1; req1 = 1'b1;
    predict(arb(1'b0, 1'b1), a1, b1, cin1);
    wait_gnt(1'b1);
    req1 = 1'b0;
    g_before = gcount;
    tick();
    a0 = 16'h5555; b0 = 16'h5555; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_drain();
    tick();
    chk("withdraw_no_gnt", (W+1)'(gcount - g_before), 0);

    // Randomized traffic
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom); req0 = 1'b1;
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom); req1 = 1'b1;
      end
      if (!p0 && !p1) begin
        tick();
        continue;
      end
      w = arb(p0, p1);
      if (w) predict(w, a1, b1, cin1);
      else   predict(w, a0, b0, cin0);
      wait_gnt(w);
      if (w) begin p1 = 1'b0; req1 = 1'b0; end
      else   begin p0 = 1'b0; req0 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
